// File: rtl/shift_left_seq_if.sv
// shift_left_seq_if: operand/result bundle for the sequential left shifter.
//
// Handshake: the requester raises start with a and b valid. The shifter
// accepts them only while busy is low, so the requester treats !busy as
// "ready". An operation is in flight from the cycle after acceptance until
// done. done is a one-cycle pulse marking res valid, and res then holds
// until the next operation completes. start seen while busy is high is
// dropped, not queued.
interface shift_left_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;

    // Requester side (ALU control)
    modport master (
        output start, a, b,
        input  busy, done, res
    );

    // Shifter side
    modport slave (
        input  start, a, b,
        output busy, done, res
    );
endinterface

// File: rtl/shift_left_seq.sv
// shift_left_seq: multi-cycle logical left shifter for sll/sllv.
// Each clock applies one barrel stage (shift by 1<<k when amt[k] is set).
// After the last stage, the result is written straight into res.
// Optional feature macro: SHIFT_LEFT_SEQ_EARLY_DONE_EN. It finishes as soon
// as no higher shift-amount bits remain, so small shifts take less time.
module shift_left_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    shift_left_seq_if.slave    bus,
    output logic [1:0]         state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q,   acc_d;
    logic [SHAMT_W-1:0] amt_q,   amt_d;
    logic [SHAMT_W-1:0] k_q,     k_d;
    logic [WIDTH-1:0]   res_q,   res_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [SHAMT_W:0]   stride;
    logic [WIDTH-1:0]   stage;

    // Next-state, datapath stage and registered-output decode
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        k_d     = k_q;
        res_d   = res_q;
        stride  = (SHAMT_W + 1)'(1) << k_q;
        stage   = amt_q[k_q] ? (acc_q << stride) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.a;
                    amt_d   = bus.b[SHAMT_W-1:0];
                    k_d     = '0;
                    state_d = S_SHIFT;
`ifdef SHIFT_LEFT_SEQ_EARLY_DONE_EN
                    // Zero shift: nothing to do, present a immediately.
                    if (bus.b[SHAMT_W-1:0] == '0) begin
                        res_d   = bus.a;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_SHIFT: begin
                acc_d = stage;
                k_d   = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    res_d   = stage;
                    state_d = S_DONE;
                end
`ifdef SHIFT_LEFT_SEQ_EARLY_DONE_EN
                // No set bits above stage k: the remaining stages are
                // pass-through, so finish now.
                else if (((amt_q >> k_q) >> 1) == '0) begin
                    res_d   = stage;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered against the next state so they line up
        // with the state they describe.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            amt_q   <= '0;
            k_q     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            k_q     <= k_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.res   = res_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_shift_left_seq.sv
// tb_shift_left_seq: directed and random checks of the sequential left
// shifter against an arithmetic reference (a * 2**n, truncated).
module tb_shift_left_seq;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    shift_left_seq_if #(.WIDTH(WIDTH)) bus ();

    shift_left_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs and observations sit 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: logical left shift as multiplication by a power of two
    function automatic logic [WIDTH-1:0] model_shift(input logic [WIDTH-1:0] a_in,
                                                     input logic [WIDTH-1:0] b_in);
        longint unsigned n;
        longint unsigned prod;
        n    = longint'(b_in) % WIDTH;
        prod = longint'(a_in) * (64'd1 << n);
        return prod[WIDTH-1:0];
    endfunction

    // Reference: cycle (relative to acceptance) at which done appears
    function automatic int model_latency(input logic [WIDTH-1:0] b_in);
        int n;
        int hi;
        n  = int'(b_in % WIDTH);
`ifdef SHIFT_LEFT_SEQ_EARLY_DONE_EN
        if (n == 0) return 1;
        hi = 0;
        for (int i = 0; i < SHAMT_W; i++)
            if (n >= (1 << i)) hi = i;
        return hi + 2;
`else
        hi = n;
        return SHAMT_W + 1;
`endif
    endfunction

    // Issue one operation and watch 12 cycles: busy until done, done once
    // at the predicted cycle with the predicted result, then idle with res held
    task automatic run_op(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                          input bit inject, input string tag);
        int lat;
        int ndone;
        logic [WIDTH-1:0] exp;
        exp = model_shift(a_in, b_in);
        lat = model_latency(b_in);
        exp_q.push_back(exp);
        bus.start = 1'b1;
        bus.a     = a_in;
        bus.b     = b_in;
        step();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        ndone = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (inject && cyc == 3) begin
                bus.start = 1'b1;
                bus.a     = 32'hFFFF_FFFF;
                bus.b     = 32'd1;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                check({tag, "_done_cycle"}, WIDTH'(cyc), WIDTH'(lat));
                if (exp_q.size() > 0) check({tag, "_res"}, bus.res, exp_q.pop_front());
                check({tag, "_busy_in_done"}, WIDTH'(bus.busy), 1);
            end else if (cyc < lat) begin
                check({tag, "_busy"}, WIDTH'(bus.busy), 1);
            end else if (cyc > lat) begin
                check({tag, "_idle"}, WIDTH'(bus.busy), 0);
                check({tag, "_hold"}, bus.res, exp);
            end
            step();
            if (inject && cyc == 3) bus.start = 1'b0;
        end
        check({tag, "_done_count"}, WIDTH'(ndone), 1);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    initial begin
        int ndone;
        int first_done;
        int last_done;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        step();
        step();
        check("reset_busy", WIDTH'(bus.busy), 0);
        check("reset_done", WIDTH'(bus.done), 0);
        check("reset_res", bus.res, 0);
        reset = 1'b0;
        step();

        // Directed operations
        run_op(32'h0000_0001, 32'd31, 1'b0, "msb");
        run_op(32'hDEAD_BEEF, 32'hFFFF_FFE4, 1'b0, "upper_ignored");
        run_op(32'h1234_5678, 32'd0, 1'b0, "zero_shift");
        run_op(32'h0000_000F, 32'd8, 1'b1, "ignored_start");
        check("ignored_start_res", bus.res, 32'h0000_0F00);

        // Reset in cycle 2 aborts the operation
        bus.start = 1'b1;
        bus.a     = 32'hAAAA_AAAA;
        bus.b     = 32'd3;
        step();
        bus.start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", WIDTH'(bus.busy), 0);
        check("abort_res", bus.res, 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) ndone++;
            step();
        end
        check("abort_no_done", WIDTH'(ndone), 0);

        // Reset and start together: start is dropped
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'h5;
        bus.b     = 32'd1;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy === 1'b1 || bus.done === 1'b1) ndone++;
            step();
        end
        check("reset_start_dropped", WIDTH'(ndone), 0);
        check("reset_start_res", bus.res, 0);
        run_op(32'h1, 32'd2, 1'b0, "after_abort");

        // start held high: back-to-back operations every SHAMT_W+2 cycles
        bus.start  = 1'b1;
        bus.a      = 32'h1;
        bus.b      = 32'd16;
        step();
        ndone      = 0;
        first_done = 0;
        last_done  = 0;
        for (int cyc = 1; cyc <= 35; cyc++) begin
            if (bus.done === 1'b1) begin
                check("stream_res", bus.res, model_shift(32'h1, 32'd16));
                if (ndone == 0) first_done = cyc;
                else check("stream_interval", WIDTH'(cyc - last_done), SHAMT_W + 2);
                last_done = cyc;
                ndone++;
            end
            step();
        end
        bus.start = 1'b0;
        check("stream_first_done", WIDTH'(first_done), WIDTH'(model_latency(32'd16)));
        check("stream_count", WIDTH'(ndone), 5);
        for (int i = 0; i < 10; i++) step();

        // Random operations
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) rb = WIDTH'($urandom_range(0, 1)) * 31;
            run_op(ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
